// File: rtl/uart_reg_master_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_reg_master_pkg
//  Description : Shared types and constants for the UART register-bus
//                initiator: op encoding, command bytes, FSM state codes.
//  Revision    : 1.0  initial release
// ============================================================================
package uart_reg_master_pkg;

    // Request op encoding; bit 1 set means a block (length-carrying) op
    localparam logic [1:0] c_op_wr  = 2'b00;
    localparam logic [1:0] c_op_rd  = 2'b01;
    localparam logic [1:0] c_op_bwr = 2'b10;
    localparam logic [1:0] c_op_brd = 2'b11;

    // Command bytes placed first on the line
    localparam logic [7:0] c_cmd_wr  = 8'h57; // 'W'
    localparam logic [7:0] c_cmd_rd  = 8'h52; // 'R'
    localparam logic [7:0] c_cmd_bwr = 8'h42; // 'B'
    localparam logic [7:0] c_cmd_brd = 8'h62; // 'b'

    // Protocol FSM states
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SEND_CMD  = 3'd1,
        ST_SEND_ADDR = 3'd2,
        ST_SEND_LEN  = 3'd3,
        ST_SEND_DATA = 3'd4,
        ST_WAIT_RSP  = 3'd5
    } state_t;

    // Receiver states
    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    function automatic logic [7:0] cmd_byte(input logic [1:0] op);
        logic [7:0] b;
        case (op)
            c_op_wr:  b = c_cmd_wr;
            c_op_rd:  b = c_cmd_rd;
            c_op_bwr: b = c_cmd_bwr;
            default:  b = c_cmd_brd;
        endcase
        return b;
    endfunction

    function automatic logic is_block(input logic [1:0] op);
        return op[1];
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_reg_master_byte_phy.sv
`default_nettype none
// ============================================================================
//  Module      : uart_reg_master_byte_phy
//  Description : 8N1 byte transmitter and receiver. The transmitter accepts a
//                new byte during the last cycle of a stop bit so consecutive
//                frames abut. The receiver synchronises the line, validates the
//                start bit at half a bit time and checks the stop bit.
//  Revision    : 1.0  initial release
// ============================================================================
module uart_reg_master_byte_phy
    import uart_reg_master_pkg::*;
#(
    parameter int BIT_TIMER = 234
) (
    input  logic       clk,
    input  logic       resetb,
    input  logic [7:0] tx_byte,
    input  logic       tx_start,
    output logic       tx_idle,
    output logic       tx_busy,
    output logic       tx_last,
    output logic       uart_tx,
    input  logic       uart_rx,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       rx_ferr
);

    localparam int CW = $clog2(BIT_TIMER + 1);
    localparam logic [CW-1:0] c_bit_last  = CW'(BIT_TIMER - 1);
    localparam logic [CW-1:0] c_half_last = CW'(BIT_TIMER / 2 - 1);

    logic          tx_busy_q, tx_busy_d;
    logic [9:0]    tx_shift_q, tx_shift_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d;
    logic [3:0]    tx_bit_q, tx_bit_d;

    logic [1:0]    sync_q, sync_d;
    logic          last_q, last_d;
    rx_state_t     rx_st_q, rx_st_d;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]    rx_bit_q, rx_bit_d;
    logic [7:0]    rx_shift_q, rx_shift_d;
    logic [7:0]    rx_byte_q, rx_byte_d;
    logic          rx_valid_q, rx_valid_d;
    logic          rx_ferr_q, rx_ferr_d;

    logic          w_rx;

    assign tx_busy  = tx_busy_q;
    assign tx_last  = tx_busy_q && (tx_bit_q == 4'd9) && (tx_cnt_q == c_bit_last);
    assign tx_idle  = !tx_busy_q || tx_last;
    // Line is forced high whenever no frame is in flight, including during reset
    assign uart_tx  = tx_busy_q ? tx_shift_q[0] : 1'b1;
    assign rx_byte  = rx_byte_q;
    assign rx_valid = rx_valid_q;
    assign rx_ferr  = rx_ferr_q;
    assign w_rx     = sync_q[1];

    // Transmit shifter: load a frame on start, otherwise shift one bit per bit time
    always_comb begin
        tx_busy_d  = tx_busy_q;
        tx_shift_d = tx_shift_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        if (tx_start && tx_idle) begin
            tx_busy_d  = 1'b1;
            tx_shift_d = {1'b1, tx_byte, 1'b0};
            tx_cnt_d   = '0;
            tx_bit_d   = 4'd0;
        end else if (tx_busy_q) begin
            if (tx_cnt_q == c_bit_last) begin
                tx_cnt_d = '0;
                if (tx_bit_q == 4'd9) begin
                    tx_busy_d = 1'b0;
                end else begin
                    tx_bit_d   = tx_bit_q + 4'd1;
                    tx_shift_d = {1'b1, tx_shift_q[9:1]};
                end
            end else begin
                tx_cnt_d = tx_cnt_q + 1'b1;
            end
        end
    end

    // Receive engine: edge detect, mid-bit sampling, stop-bit check
    always_comb begin
        sync_d     = {sync_q[0], uart_rx};
        last_d     = sync_q[1];
        rx_st_d    = rx_st_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_byte_d  = rx_byte_q;
        rx_valid_d = 1'b0;
        rx_ferr_d  = 1'b0;
        case (rx_st_q)
            RX_IDLE: begin
                if (!w_rx && last_q) begin
                    rx_st_d  = RX_START;
                    rx_cnt_d = '0;
                end
            end
            RX_START: begin
                if (rx_cnt_q == c_half_last) begin
                    rx_cnt_d = '0;
                    rx_bit_d = 3'd0;
                    // A start bit that is high again at mid-bit was a glitch
                    rx_st_d  = w_rx ? RX_IDLE : RX_DATA;
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            RX_DATA: begin
                if (rx_cnt_q == c_bit_last) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {w_rx, rx_shift_q[7:1]};
                    if (rx_bit_q == 3'd7) begin
                        rx_st_d = RX_STOP;
                    end else begin
                        rx_bit_d = rx_bit_q + 3'd1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            default: begin
                if (rx_cnt_q == c_bit_last) begin
                    rx_st_d = RX_IDLE;
                    if (w_rx) begin
                        rx_valid_d = 1'b1;
                        rx_byte_d  = rx_shift_q;
                    end else begin
                        rx_ferr_d = 1'b1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
        endcase
    end

    // State registers for both engines
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            tx_busy_q  <= 1'b0;
            tx_shift_q <= '1;
            tx_cnt_q   <= '0;
            tx_bit_q   <= 4'd0;
            sync_q     <= 2'b11;
            last_q     <= 1'b1;
            rx_st_q    <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= 3'd0;
            rx_shift_q <= 8'h00;
            rx_byte_q  <= 8'h00;
            rx_valid_q <= 1'b0;
            rx_ferr_q  <= 1'b0;
        end else begin
            tx_busy_q  <= tx_busy_d;
            tx_shift_q <= tx_shift_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            sync_q     <= sync_d;
            last_q     <= last_d;
            rx_st_q    <= rx_st_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_byte_q  <= rx_byte_d;
            rx_valid_q <= rx_valid_d;
            rx_ferr_q  <= rx_ferr_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_reg_master.sv
`default_nettype none
// ============================================================================
//  Module      : uart_reg_master
//  Description : UART register-bus initiator. Sends W/R/B/b command frames,
//                streams write bytes from the host and returns read bytes as
//                single-cycle pulses, with a response timeout.
//  Revision    : 1.0  initial release
// ============================================================================
module uart_reg_master
    import uart_reg_master_pkg::*;
#(
    parameter int CLK_FREQ    = 27000000,
    parameter int BAUD_RATE   = 115200,
    parameter int RSP_TIMEOUT = 64
) (
    input  logic       clk,
    input  logic       resetb,
    output logic       uart_tx,
    input  logic       uart_rx,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [1:0] req_op,
    input  logic [7:0] req_addr,
    input  logic [7:0] req_len,
    input  logic [7:0] wr_data,
    input  logic       wr_valid,
    output logic       wr_ready,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    output logic       done,
    output logic       timeout,
    output logic       frame_err,
    output logic       busy
);

    localparam int BIT_TIMER = CLK_FREQ / BAUD_RATE;
    localparam int TO_LIMIT  = RSP_TIMEOUT * BIT_TIMER;
    localparam int TO_W      = $clog2(TO_LIMIT + 1);
    localparam logic [TO_W-1:0] c_to_last = TO_W'(TO_LIMIT - 1);

    state_t         state_q, state_d;
    logic [1:0]     op_q, op_d;
    logic [7:0]     addr_q, addr_d;
    logic [7:0]     len_q, len_d;
    logic [8:0]     remain_q, remain_d;   // 9 bits so len=255 never wraps
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic [7:0]     rd_data_q, rd_data_d;
    logic           rd_valid_q, rd_valid_d;
    logic           done_q, done_d;
    logic           timeout_q, timeout_d;
    logic           frame_err_q, frame_err_d;

    logic           w_tx_start;
    logic [7:0]     w_tx_byte;
    logic           w_tx_idle;
    logic           w_tx_busy;
    logic           w_tx_last;
    logic [7:0]     w_rx_byte;
    logic           w_rx_valid;
    logic           w_rx_ferr;

    uart_reg_master_byte_phy #(
        .BIT_TIMER (BIT_TIMER)
    ) u_phy (
        .clk      (clk),
        .resetb   (resetb),
        .tx_byte  (w_tx_byte),
        .tx_start (w_tx_start),
        .tx_idle  (w_tx_idle),
        .tx_busy  (w_tx_busy),
        .tx_last  (w_tx_last),
        .uart_tx  (uart_tx),
        .uart_rx  (uart_rx),
        .rx_byte  (w_rx_byte),
        .rx_valid (w_rx_valid),
        .rx_ferr  (w_rx_ferr)
    );

    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign done      = done_q;
    assign timeout   = timeout_q;
    assign frame_err = frame_err_q;

    // State and datapath registers
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state_q     <= ST_IDLE;
            op_q        <= c_op_wr;
            addr_q      <= 8'h00;
            len_q       <= 8'h00;
            remain_q    <= 9'd0;
            to_cnt_q    <= '0;
            rd_data_q   <= 8'h00;
            rd_valid_q  <= 1'b0;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            remain_q    <= remain_d;
            to_cnt_q    <= to_cnt_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
            done_q      <= done_d;
            timeout_q   <= timeout_d;
            frame_err_q <= frame_err_d;
        end
    end

    // Next-state logic: header sequencing, byte counting, response timeout
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        addr_d      = addr_q;
        len_d       = len_q;
        remain_d    = remain_q;
        to_cnt_d    = to_cnt_q;
        rd_data_d   = rd_data_q;
        rd_valid_d  = 1'b0;
        done_d      = 1'b0;
        timeout_d   = 1'b0;
        frame_err_d = w_rx_ferr;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    op_d     = req_op;
                    addr_d   = req_addr;
                    len_d    = req_len;
                    remain_d = is_block(req_op) ? {1'b0, req_len} : 9'd1;
                    // Zero-length block: nothing to send, complete immediately
                    if (is_block(req_op) && (req_len == 8'h00)) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = ST_SEND_CMD;
                    end
                end
            end
            ST_SEND_CMD: begin
                if (w_tx_idle) begin
                    state_d = ST_SEND_ADDR;
                end
            end
            ST_SEND_ADDR: begin
                if (w_tx_idle) begin
                    to_cnt_d = '0;
                    case (op_q)
                        c_op_wr: state_d = ST_SEND_DATA;
                        c_op_rd: state_d = ST_WAIT_RSP;
                        default: state_d = ST_SEND_LEN;
                    endcase
                end
            end
            ST_SEND_LEN: begin
                if (w_tx_idle) begin
                    to_cnt_d = '0;
                    state_d  = (op_q == c_op_bwr) ? ST_SEND_DATA : ST_WAIT_RSP;
                end
            end
            ST_SEND_DATA: begin
                if (w_tx_start) begin
                    remain_d = remain_q - 9'd1;
                end else if ((remain_q == 9'd0) && w_tx_last) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT_RSP: begin
                if (w_rx_valid) begin
                    rd_valid_d = 1'b1;
                    rd_data_d  = w_rx_byte;
                    to_cnt_d   = '0;
                    remain_d   = remain_q - 9'd1;
                    if (remain_q == 9'd1) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end else if (w_tx_busy) begin
                    // Timeout window opens only once the header has left the line
                    to_cnt_d = '0;
                end else if (to_cnt_q == c_to_last) begin
                    timeout_d = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output decode: handshakes and the byte offered to the transmitter
    always_comb begin
        req_ready  = (state_q == ST_IDLE);
        busy       = (state_q != ST_IDLE);
        wr_ready   = (state_q == ST_SEND_DATA) && (remain_q != 9'd0) && w_tx_idle;
        w_tx_start = 1'b0;
        w_tx_byte  = 8'h00;
        case (state_q)
            ST_SEND_CMD: begin
                w_tx_start = w_tx_idle;
                w_tx_byte  = cmd_byte(op_q);
            end
            ST_SEND_ADDR: begin
                w_tx_start = w_tx_idle;
                w_tx_byte  = addr_q;
            end
            ST_SEND_LEN: begin
                w_tx_start = w_tx_idle;
                w_tx_byte  = len_q;
            end
            ST_SEND_DATA: begin
                w_tx_start = wr_valid && wr_ready;
                w_tx_byte  = wr_data;
            end
            default: begin
                w_tx_start = 1'b0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_reg_master.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_reg_master
//  Description : Directed bench for uart_reg_master with a line decoder and a
//                UART slave reply driver (BIT_TIMER = 10).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_uart_reg_master;

    localparam int CLK_FREQ    = 1000000;
    localparam int BAUD_RATE   = 100000;
    localparam int RSP_TIMEOUT = 64;

    logic       clk = 1'b0;
    logic       resetb = 1'b0;
    logic       uart_tx;
    logic       uart_rx = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [1:0] req_op = 2'b00;
    logic [7:0] req_addr = 8'h00;
    logic [7:0] req_len = 8'h00;
    logic [7:0] wr_data = 8'h00;
    logic       wr_valid = 1'b0;
    logic       wr_ready;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       done;
    logic       timeout;
    logic       frame_err;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [7:0] tx_q[$];
    int         tx_t[$];
    int         tx_stop_bad = 0;
    logic [7:0] rd_q[$];
    int         rd_last_cyc = -1;
    int         done_cnt = 0;
    int         done_cyc = -1;
    int         to_cnt = 0;
    int         to_cyc = -1;
    int         ferr_cnt = 0;

    uart_reg_master #(
        .CLK_FREQ    (CLK_FREQ),
        .BAUD_RATE   (BAUD_RATE),
        .RSP_TIMEOUT (RSP_TIMEOUT)
    ) dut (
        .clk       (clk),
        .resetb    (resetb),
        .uart_tx   (uart_tx),
        .uart_rx   (uart_rx),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_addr  (req_addr),
        .req_len   (req_len),
        .wr_data   (wr_data),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .done      (done),
        .timeout   (timeout),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Pulse recorders
    always @(negedge clk) begin
        if (rd_valid === 1'b1) begin
            rd_q.push_back(rd_data);
            rd_last_cyc = cyc;
        end
        if (done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (timeout === 1'b1) begin
            to_cnt++;
            to_cyc = cyc;
        end
        if (frame_err === 1'b1) ferr_cnt++;
    end

    // Line decoder: start detected on the first low sample, bits read mid-bit
    initial begin : line_decoder
        logic       prev;
        logic [7:0] b;
        int         t;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (prev === 1'b1 && uart_tx === 1'b0) begin
                t = cyc;
                repeat (15) @(negedge clk);
                b[0] = uart_tx;
                for (int i = 1; i < 8; i++) begin
                    repeat (10) @(negedge clk);
                    b[i] = uart_tx;
                end
                repeat (10) @(negedge clk);
                if (uart_tx !== 1'b1) tx_stop_bad++;
                tx_q.push_back(b);
                tx_t.push_back(t);
            end
            prev = uart_tx;
        end
    end

    task automatic clear_mon();
        tx_q.delete();
        tx_t.delete();
        rd_q.delete();
        tx_stop_bad = 0;
        rd_last_cyc = -1;
        done_cnt    = 0;
        done_cyc    = -1;
        to_cnt      = 0;
        to_cyc      = -1;
        ferr_cnt    = 0;
    endtask

    task automatic do_req(input logic [1:0] op, input logic [7:0] addr,
                          input logic [7:0] len, output int acc);
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = addr;
        req_len   = len;
        acc       = cyc + 1;
        @(negedge clk);
        req_valid = 1'b0;
        req_op    = 2'b00;
        req_addr  = 8'hEE;
        req_len   = 8'hEE;
    endtask

    task automatic wait_tx(input int n, input int bound, output bit ok);
        int k = 0;
        while (tx_q.size() < n && k < bound) begin
            @(negedge clk);
            k++;
        end
        ok = (tx_q.size() >= n);
    endtask

    task automatic wait_done(input int bound, output bit ok);
        int k = 0;
        while (done_cnt == 0 && k < bound) begin
            @(negedge clk);
            k++;
        end
        ok = (done_cnt != 0);
    endtask

    task automatic push_wr(input logic [7:0] d, output bit ok);
        int k = 0;
        @(negedge clk);
        wr_data  = d;
        wr_valid = 1'b1;
        while (wr_ready !== 1'b1 && k < 2000) begin
            @(negedge clk);
            k++;
        end
        ok = (wr_ready === 1'b1);
        @(negedge clk);
        wr_valid = 1'b0;
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop);
        @(negedge clk);
        uart_rx = 1'b0;
        repeat (10) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (10) @(negedge clk);
        end
        uart_rx = stop;
        repeat (10) @(negedge clk);
        uart_rx = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_checks++;
        if (uart_tx !== 1'b1) begin n_fail++; $display("FAIL reset_uart_tx: got %b want 1", uart_tx); end
        n_checks++;
        if ({req_ready, busy, wr_ready} !== 3'b100) begin
            n_fail++; $display("FAIL reset_handshake: got rdy/busy/wrr=%b want 100", {req_ready, busy, wr_ready});
        end
        n_checks++;
        if ({rd_data, rd_valid, done, timeout, frame_err} !== 12'h000) begin
            n_fail++; $display("FAIL reset_outputs: got %h want 000", {rd_data, rd_valid, done, timeout, frame_err});
        end
        resetb = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_single_write();
        int acc; bit ok1, ok2;
        clear_mon();
        wr_data = 8'hA5; wr_valid = 1'b1;
        do_req(2'b00, 8'h12, 8'h00, acc);
        wait_tx(3, 1000, ok1);
        wait_done(200, ok2);
        wr_valid = 1'b0;
        repeat (20) @(negedge clk);
        n_checks++;
        if (!(ok1 && ok2)) begin n_fail++; $display("FAIL w_wait: bytes_ok=%0d done_ok=%0d want 1 1", ok1, ok2); end
        n_checks++;
        if ({tx_q[0], tx_q[1], tx_q[2]} !== 24'h5712A5) begin
            n_fail++; $display("FAIL w_bytes: got %h want 5712a5", {tx_q[0], tx_q[1], tx_q[2]});
        end
        n_checks++;
        if (tx_t[0] != acc + 1 || tx_t[2] - tx_t[0] != 200 || tx_stop_bad != 0) begin
            n_fail++; $display("FAIL w_timing: start=%0d span=%0d badstop=%0d want %0d 200 0", tx_t[0], tx_t[2] - tx_t[0], tx_stop_bad, acc + 1);
        end
        n_checks++;
        if (done_cnt != 1 || done_cyc != tx_t[2] + 100) begin
            n_fail++; $display("FAIL w_done: count=%0d cyc=%0d want 1 %0d", done_cnt, done_cyc, tx_t[2] + 100);
        end
        n_checks++;
        if (rd_q.size() != 0) begin n_fail++; $display("FAIL w_no_rd: got %0d rd_valid want 0", rd_q.size()); end
    endtask

    task automatic test_single_read();
        int acc; bit ok1, ok2;
        clear_mon();
        do_req(2'b01, 8'h34, 8'h00, acc);
        wait_tx(2, 1000, ok1);
        send_rx(8'h5A, 1'b1);
        wait_done(300, ok2);
        repeat (20) @(negedge clk);
        n_checks++;
        if (!(ok1 && ok2)) begin n_fail++; $display("FAIL r_wait: bytes_ok=%0d done_ok=%0d want 1 1", ok1, ok2); end
        n_checks++;
        if (tx_q.size() != 2 || {tx_q[0], tx_q[1]} !== 16'h5234) begin
            n_fail++; $display("FAIL r_bytes: n=%0d got %h want 2 5234", tx_q.size(), {tx_q[0], tx_q[1]});
        end
        n_checks++;
        if (rd_q.size() != 1 || rd_q[0] !== 8'h5A || rd_data !== 8'h5A) begin
            n_fail++; $display("FAIL r_data: n=%0d q0=%h rd_data=%h want 1 5a 5a", rd_q.size(), rd_q[0], rd_data);
        end
        n_checks++;
        if (done_cnt != 1 || done_cyc != rd_last_cyc) begin
            n_fail++; $display("FAIL r_done: count=%0d cyc=%0d want 1 %0d", done_cnt, done_cyc, rd_last_cyc);
        end
    endtask

    task automatic test_block_write_stall();
        int acc; int bad; bit ok1, ok2, ok3, ok4, ok5;
        clear_mon();
        do_req(2'b10, 8'h10, 8'h03, acc);
        push_wr(8'h01, ok1);
        bad = 0;
        for (int k = 0; k < 250; k++) begin
            @(negedge clk);
            if (k >= 110 && uart_tx !== 1'b1) bad++;
        end
        push_wr(8'h02, ok2);
        push_wr(8'h03, ok3);
        wait_tx(6, 1000, ok4);
        wait_done(200, ok5);
        repeat (20) @(negedge clk);
        n_checks++;
        if (!(ok1 && ok2 && ok3 && ok4 && ok5)) begin
            n_fail++; $display("FAIL bw_wait: flags=%b want 11111", {ok1, ok2, ok3, ok4, ok5});
        end
        n_checks++;
        if ({tx_q[0], tx_q[1], tx_q[2], tx_q[3], tx_q[4], tx_q[5]} !== 48'h421003010203) begin
            n_fail++; $display("FAIL bw_bytes: got %h want 421003010203", {tx_q[0], tx_q[1], tx_q[2], tx_q[3], tx_q[4], tx_q[5]});
        end
        n_checks++;
        if (tx_t[3] - tx_t[2] != 100 || tx_t[4] - tx_t[3] < 250 || bad != 0) begin
            n_fail++; $display("FAIL bw_gap: d23=%0d d34=%0d low=%0d want 100 >=250 0", tx_t[3] - tx_t[2], tx_t[4] - tx_t[3], bad);
        end
        n_checks++;
        if (done_cnt != 1 || done_cyc != tx_t[5] + 100) begin
            n_fail++; $display("FAIL bw_done: count=%0d cyc=%0d want 1 %0d", done_cnt, done_cyc, tx_t[5] + 100);
        end
    endtask

    task automatic test_block_read();
        int acc; int errs; bit ok1, ok2;
        logic [7:0] exp_b;
        clear_mon();
        do_req(2'b11, 8'h20, 8'h04, acc);
        wait_tx(3, 1000, ok1);
        send_rx(8'h11, 1'b1);
        send_rx(8'h22, 1'b1);
        send_rx(8'h33, 1'b1);
        send_rx(8'h44, 1'b1);
        wait_done(300, ok2);
        repeat (20) @(negedge clk);
        n_checks++;
        if (!(ok1 && ok2)) begin n_fail++; $display("FAIL br_wait: bytes_ok=%0d done_ok=%0d want 1 1", ok1, ok2); end
        n_checks++;
        if ({tx_q[0], tx_q[1], tx_q[2]} !== 24'h622004) begin
            n_fail++; $display("FAIL br_bytes: got %h want 622004", {tx_q[0], tx_q[1], tx_q[2]});
        end
        n_checks++;
        if (rd_q.size() != 4 || {rd_q[0], rd_q[1], rd_q[2], rd_q[3]} !== 32'h11223344) begin
            n_fail++; $display("FAIL br_data: n=%0d got %h want 4 11223344", rd_q.size(), {rd_q[0], rd_q[1], rd_q[2], rd_q[3]});
        end
        n_checks++;
        if (done_cnt != 1 || done_cyc != rd_last_cyc) begin
            n_fail++; $display("FAIL br_done: count=%0d cyc=%0d want 1 %0d", done_cnt, done_cyc, rd_last_cyc);
        end

        // Full 255-byte block
        clear_mon();
        do_req(2'b11, 8'h21, 8'hFF, acc);
        wait_tx(3, 1000, ok1);
        for (int i = 0; i < 255; i++) begin
            exp_b = 8'(i) ^ 8'h3C;
            send_rx(exp_b, 1'b1);
        end
        wait_done(300, ok2);
        repeat (20) @(negedge clk);
        errs = 0;
        for (int i = 0; i < rd_q.size(); i++) begin
            exp_b = 8'(i) ^ 8'h3C;
            if (rd_q[i] !== exp_b) errs++;
        end
        n_checks++;
        if (tx_q[2] !== 8'hFF || rd_q.size() != 255 || errs != 0) begin
            n_fail++; $display("FAIL br255_data: len_byte=%h n=%0d errs=%0d want ff 255 0", tx_q[2], rd_q.size(), errs);
        end
        n_checks++;
        if (done_cnt != 1 || done_cyc != rd_last_cyc) begin
            n_fail++; $display("FAIL br255_done: count=%0d cyc=%0d want 1 %0d", done_cnt, done_cyc, rd_last_cyc);
        end
    endtask

    task automatic test_timeout_and_frame_err();
        int acc; int k; bit ok1, ok2;
        clear_mon();
        do_req(2'b01, 8'h40, 8'h00, acc);
        wait_tx(2, 1000, ok1);
        k = 0;
        while (to_cnt == 0 && k < 2000) begin
            @(negedge clk);
            k++;
        end
        @(negedge clk);
        n_checks++;
        if (!ok1 || to_cnt != 1 || to_cyc != tx_t[1] + 740) begin
            n_fail++; $display("FAIL to_pulse: count=%0d cyc=%0d want 1 %0d", to_cnt, to_cyc, tx_t[1] + 740);
        end
        n_checks++;
        if (done_cnt != 0 || req_ready !== 1'b1 || rd_q.size() != 0) begin
            n_fail++; $display("FAIL to_state: done=%0d req_ready=%b rd=%0d want 0 1 0", done_cnt, req_ready, rd_q.size());
        end

        // Bad-stop byte during a read is dropped; the following good byte completes it
        clear_mon();
        do_req(2'b01, 8'h41, 8'h00, acc);
        wait_tx(2, 1000, ok1);
        send_rx(8'h77, 1'b0);
        repeat (10) @(negedge clk);
        send_rx(8'h66, 1'b1);
        wait_done(300, ok2);
        repeat (20) @(negedge clk);
        n_checks++;
        if (ferr_cnt != 1 || rd_q.size() != 1 || rd_q[0] !== 8'h66) begin
            n_fail++; $display("FAIL ferr: ferr=%0d rd_n=%0d q0=%h want 1 1 66", ferr_cnt, rd_q.size(), rd_q[0]);
        end
        n_checks++;
        if (!(ok1 && ok2) || done_cnt != 1) begin
            n_fail++; $display("FAIL ferr_done: ok=%b count=%0d want 11 1", {ok1, ok2}, done_cnt);
        end
    endtask

    task automatic test_async_reset_and_len0();
        int acc; int k; bit ok1, ok2;
        clear_mon();
        do_req(2'b10, 8'h10, 8'h02, acc);
        repeat (150) @(negedge clk);
        k = 0;
        while (uart_tx !== 1'b0 && k < 100) begin
            @(negedge clk);
            k++;
        end
        #1 resetb = 1'b0;
        #1;
        n_checks++;
        if (uart_tx !== 1'b1 || req_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL rst_async: tx=%b rdy=%b busy=%b want 1 1 0", uart_tx, req_ready, busy);
        end
        repeat (3) @(negedge clk);
        resetb = 1'b1;
        repeat (200) @(negedge clk);
        clear_mon();
        wr_data = 8'hAA; wr_valid = 1'b1;
        do_req(2'b00, 8'h55, 8'h00, acc);
        wait_tx(3, 1000, ok1);
        wait_done(200, ok2);
        wr_valid = 1'b0;
        repeat (20) @(negedge clk);
        n_checks++;
        if (!(ok1 && ok2) || {tx_q[0], tx_q[1], tx_q[2]} !== 24'h5755AA || done_cnt != 1) begin
            n_fail++; $display("FAIL rst_then_w: got %h done=%0d want 5755aa 1", {tx_q[0], tx_q[1], tx_q[2]}, done_cnt);
        end

        clear_mon();
        do_req(2'b11, 8'h20, 8'h00, acc);
        repeat (200) @(negedge clk);
        n_checks++;
        if (tx_q.size() != 0 || done_cnt != 1 || done_cyc != acc) begin
            n_fail++; $display("FAIL len0: bytes=%0d done=%0d cyc=%0d want 0 1 %0d", tx_q.size(), done_cnt, done_cyc, acc);
        end
    endtask

    initial begin : watchdog
        #5000000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : main
        test_reset();
        test_single_write();
        test_single_read();
        test_block_write_stall();
        test_block_read();
        test_timeout_and_frame_err();
        test_async_reset_and_len0();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
